rr_req_arbiter8: RTL and testbench

Round-robin arbiter that shares one downstream resource between eight requesters and hands out a registered one-hot grant together with its 3-bit encoded index. It sits in front of the 8-to-3 encoding path: the grant it produces is one-hot by construction, so the encoded index is always unambiguous. Each grant is held until the owner signals `done`, until a hold-limit timeout fires, or until the enable is withdrawn.

---
 rtl/rr_req_arbiter8_pkg.sv | 7 +
 rtl/rr_req_arbiter8_pick8.sv | 33 +++
 rtl/rr_req_arbiter8.sv | 75 +++++++
 tb/tb_rr_req_arbiter8.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rr_req_arbiter8_pkg.sv
// Shared types and sizes for the eight-way round-robin request arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/rr_req_arbiter8_pick8.sv
// Combinational round-robin pick: rotate so ptr lands at bit 0, take lowest set bit, rotate back.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] back;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   sel;
  logic [IDX_W-1:0]   pos;

  always_comb begin
    dbl  = {req, req} >> ptr;
    rot  = dbl[N_REQ-1:0];
    sel  = rot & (~rot + 8'd1);
    back = {sel, sel} << ptr;
    pick = back[2*N_REQ-1:N_REQ];
    pos  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel[i]) pos = 3'(i);
    end
    // Position in the rotated frame plus ptr is the original index, mod 8.
    pick_idx = pos + ptr;
    any      = |req;
  end

endmodule

// File: rtl/rr_req_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, encoded index and hold-limit timeout.
module rr_req_arbiter8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = $clog2(HOLD_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             any;

  rr_pick8 u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && any) begin
            gnt       <= pick;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!en || done || cnt == CNT_MAX) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            state     <= IDLE;
            // Only a release forced by the hold limit counts as a timeout.
            timeout   <= en && !done;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_req_arbiter8.sv
// Bench for rr_req_arbiter8: directed scenarios plus random traffic against a cycle model.
module tb_rr_req_arbiter8;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst, en, done;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid, timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: who owns the resource, for how many cycles, and who is next in line.
  bit         m_busy;
  int         m_owner;
  int         m_held;
  int         m_next;
  bit         m_to;

  rr_req_arbiter8 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_release();
    m_next = (m_owner + 1) % 8;
    m_busy = 1'b0;
  endtask

  task automatic model_edge();
    m_to = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_held = 0; m_next = 0; m_owner = 0;
    end else if (!m_busy) begin
      if (en && req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_next + k) % 8]) begin
            m_owner = (m_next + k) % 8;
            break;
          end
        end
        m_busy = 1'b1;
        m_held = 1;
      end
    end else if (!en || done) begin
      model_release();
    end else if (m_held == HOLD) begin
      model_release();
      m_to = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] q, input logic d);
    rst = r; en = e; req = q; done = d;
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", gnt, m_busy ? 8'(1 << m_owner) : 8'h00);
    check("gnt_idx", {5'd0, gnt_idx}, m_busy ? 8'(m_owner) : 8'h00);
    check("gnt_valid", {7'd0, gnt_valid}, {7'd0, m_busy});
    check("timeout", {7'd0, timeout}, {7'd0, m_to});
  endtask

  initial begin
    m_busy = 0; m_owner = 0; m_held = 0; m_next = 0; m_to = 0;
    rst = 1; en = 1; req = 8'hFF; done = 0;

    // Reset held with all requests pending.
    step(1, 1, 8'hFF, 0);
    check("rst_gnt", gnt, 8'h00);
    step(1, 1, 8'hFF, 0);
    check("rst_valid", {7'd0, gnt_valid}, 8'h00);
    step(0, 1, 8'hFF, 0);
    check("post_rst_gnt", gnt, 8'h01);
    check("post_rst_idx", {5'd0, gnt_idx}, 8'h00);

    // Pointer rotation and wrap.
    step(1, 1, 8'h81, 0);
    step(0, 1, 8'h81, 0);
    check("rot_first", gnt, 8'h01);
    step(0, 1, 8'h81, 1);
    check("rot_gap", gnt, 8'h00);
    step(0, 1, 8'h81, 0);
    check("rot_second", gnt, 8'h80);
    check("rot_second_idx", {5'd0, gnt_idx}, 8'h07);
    step(0, 1, 8'h81, 1);
    step(0, 1, 8'h81, 0);
    check("rot_wrap_idx", {5'd0, gnt_idx}, 8'h00);

    // Full fairness with every requester active.
    step(1, 1, 8'hFF, 0);
    for (int g = 0; g < 10; g++) begin
      step(0, 1, 8'hFF, 0);
      check("fair_idx", {5'd0, gnt_idx}, 8'(g % 8));
      step(0, 1, 8'hFF, 1);
      check("fair_gap", {7'd0, gnt_valid}, 8'h00);
    end

    // Hold-limit timeout with a single requester.
    step(1, 1, 8'h04, 0);
    for (int c = 0; c < HOLD; c++) begin
      step(0, 1, 8'h04, 0);
      check("to_hold_idx", {5'd0, gnt_idx}, 8'h02);
      check("to_hold_valid", {7'd0, gnt_valid}, 8'h01);
    end
    step(0, 1, 8'h04, 0);
    check("to_drop", gnt, 8'h00);
    check("to_pulse", {7'd0, timeout}, 8'h01);
    step(0, 1, 8'h04, 0);
    check("to_regrant", {5'd0, gnt_idx}, 8'h02);
    check("to_pulse_end", {7'd0, timeout}, 8'h00);

    // done coinciding with the last allowed hold cycle.
    step(1, 1, 8'h04, 0);
    step(0, 1, 8'h04, 0);
    for (int c = 0; c < HOLD - 1; c++) step(0, 1, 8'h04, 0);
    step(0, 1, 8'h04, 1);
    check("coinc_drop", gnt, 8'h00);
    check("coinc_no_to", {7'd0, timeout}, 8'h00);

    // Enable withdrawn mid-grant.
    step(1, 1, 8'h30, 0);
    step(0, 1, 8'h30, 0);
    check("abort_idx", {5'd0, gnt_idx}, 8'h04);
    step(0, 1, 8'h30, 0);
    step(0, 0, 8'h30, 0);
    check("abort_drop", gnt, 8'h00);
    check("abort_no_to", {7'd0, timeout}, 8'h00);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 8'h30, 0);
      check("abort_blocked", {7'd0, gnt_valid}, 8'h00);
    end
    step(0, 1, 8'h30, 0);
    check("abort_resume_idx", {5'd0, gnt_idx}, 8'h05);

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
           8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
